// File: rtl/mul_seq_pkg.sv
// Shared types and sizes for the iterative shift-add multiplier.
// The optional early-exit feature is selected with MUL_SEQ_EARLY_TERM_EN.
package mul_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// The clk port exists for slot compatibility; the adder is purely combinational.
module mul_seq_cla
  import mul_seq_pkg::*;
(
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic             unused_clk;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             gg;
  logic             pg;

  assign unused_clk = clk;
  assign g = a & op2;
  assign p = a ^ op2;

  always_comb begin
    c    = '0;
    gg   = 1'b0;
    pg   = 1'b0;
    c[0] = cin;
    for (int k = 0; k < WIDTH / 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      c[4*k+4] = gg | (pg & c[4*k]);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/mul_shift_add_seq.sv
// Iterative 32x32 unsigned shift-add multiplier, one conditional add per cycle.
// MUL_SEQ_EARLY_TERM_EN: exit as soon as the remaining multiplier bits are zero.
module mul_shift_add_seq
  import mul_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   op2;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fin;
  logic               last;
  logic               accept;

  mul_seq_cla u_cla (
    .clk  (clk),
    .a    (acc_q),
    .op2  (op2),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign op2  = q_q[0] ? m_q : '0;
  assign prod = {cout, sum, q_q[WIDTH-1:1]};

`ifdef MUL_SEQ_EARLY_TERM_EN
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] mask;

  // Zero-valued remaining iterations only shift, so do them all at once.
  always_comb begin
    rem      = CNT_W'(WIDTH - 1) - cnt_q;
    mask     = (WIDTH'(1) << rem) - WIDTH'(1);
    last     = ((q_q >> 1) & mask) == '0;
    prod_fin = last ? (prod >> rem) : prod;
  end
`else
  always_comb begin
    last     = cnt_q == CNT_W'(WIDTH - 1);
    prod_fin = prod;
  end
`endif

  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        {acc_d, q_d} = prod_fin;
        cnt_d        = cnt_q + CNT_W'(1);
        if (last) begin
          state_d      = DONE;
          {hi_d, lo_d} = prod_fin;
        end
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      m_d   = op_a;
      q_d   = op_b;
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign result_hi = hi_q;
  assign result_lo = lo_q;

endmodule

// File: tb/tb_mul_shift_add_seq.sv
// Directed bench for mul_shift_add_seq; latency model follows
// MUL_SEQ_EARLY_TERM_EN when it is defined.
module tb_mul_shift_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  int tests = 0;
  int fails = 0;

  mul_shift_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges from accept (edge 1) until done is visible.
  function automatic int lat(input logic [31:0] b);
    int n;
`ifdef MUL_SEQ_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++)
      if (b[i]) n = i + 1;
    return n + 1;
`else
    n = 33;
    if (b === 32'hx) n = 0;
    return n;
`endif
  endfunction

  task automatic run_mul(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int n;
    bit seen;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (n == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      seen = done;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat(b)));
    check({tag, "_res"}, {result_hi, result_lo}, exp);
    check({tag, "_nbusy"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    bit seen;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #1;
    check("por", {30'd0, busy, done, result_hi, result_lo}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_mul("mul7x6", 32'd7, 32'd6, 64'h0000_0000_0000_002A);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_rst", {30'd0, busy, done, result_hi, result_lo}, '0);
    @(negedge clk);
    rst = 1'b0;

    run_mul("maxsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            64'hFFFF_FFFE_0000_0001);

    // start held high: back-to-back issue, mid-run operand change ignored
    @(negedge clk);
    op_a  = 32'd3;
    op_b  = 32'd5;
    start = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        op_a = 32'h0001_0000;
        op_b = 32'h0001_0000;
      end
      seen = done;
    end
    check("b2b_lat1", 64'(n), 64'(lat(32'd5)));
    check("b2b_res1", {result_hi, result_lo}, 64'h0000_0000_0000_000F);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen = done;
    end
    start = 1'b0;
    check("b2b_lat2", 64'(n), 64'(lat(32'h0001_0000)));
    check("b2b_res2", {result_hi, result_lo}, 64'h0000_0001_0000_0000);
    @(posedge clk);
    #1;
    check("b2b_idle", {62'd0, busy, done}, '0);

    // reset in the 10th RUN cycle
    @(negedge clk);
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h0000_1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_zero", {30'd0, busy, done, result_hi, result_lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_nodone", 64'(done), 64'd0);

    run_mul("mul2x2", 32'd2, 32'd2, 64'd4);

`ifdef MUL_SEQ_EARLY_TERM_EN
    run_mul("et_by1", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678);
    run_mul("et_by0", 32'h1234_5678, 32'd0, 64'd0);
    run_mul("et_msb", 32'd3, 32'h8000_0000, 64'h0000_0001_8000_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
